// File: rtl/instruction_fetch_if.sv
// Signal bundle around the fetch stage: instruction-memory port, redirect from
// execute and the {instruction, pc} handshake towards decode.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instruction, instruction_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instruction, instruction_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, credit-limited requests to instruction memory, PC-tag
// queue for in-order responses, and a small output FIFO towards decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] in_flight_next;
    logic [CNT_W-1:0] live;
    logic [CNT_W-1:0] occupancy;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic [TAG_W-1:0] tag_wr;
    logic [TAG_W-1:0] tag_rd;
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [31:0]      tag_pc     [MAX_OUTSTANDING];

    logic req_hs;
    logic resp_ok;
    logic push;
    logic pop;
    logic redirect;
    logic unused_redirect_bits;

    function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TAG_W'(1);
    endfunction

    assign fifo_count = wr_ptr - rd_ptr;
    assign live       = in_flight - drop_cnt;
    assign occupancy  = live + CNT_W'(fifo_count);

    // Gated by rst_n so no request can be accepted in a reset cycle and answered afterwards.
    assign bus.imem_req_valid = rst_n
                             && (in_flight < CNT_W'(MAX_OUTSTANDING))
                             && (occupancy < CNT_W'(FIFO_DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = (fifo_count != '0);

    assign redirect       = bus.redirect_valid;
    assign req_hs         = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_ok        = bus.imem_resp_valid && (in_flight != '0);
    assign push           = resp_ok && (drop_cnt == '0) && !redirect;
    assign pop            = bus.instr_valid && bus.instr_ready && !redirect;
    assign in_flight_next = in_flight + CNT_W'(req_hs) - CNT_W'(resp_ok);

    assign unused_redirect_bits = ^bus.redirect_pc[1:0];

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        bus.instruction    = '0;
        bus.instruction_pc = '0;
        if (bus.instr_valid) begin
            bus.instruction    = fifo_instr[rd_ptr[PTR_W-1:0]];
            bus.instruction_pc = fifo_pc[rd_ptr[PTR_W-1:0]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_wr    <= '0;
            tag_rd    <= '0;
        end else begin
            in_flight <= in_flight_next;
            if (redirect) begin
                // Everything still outstanding after this edge is stale, including this cycle's request.
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                drop_cnt <= in_flight_next;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                tag_wr   <= '0;
                tag_rd   <= '0;
            end else begin
                if (req_hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    tag_wr   <= tag_inc(tag_wr);
                end
                if (resp_ok && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
                    tag_rd <= tag_inc(tag_rd);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
                end
            end
        end
    end

    // NOTE: storage arrays carry no reset; pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (req_hs && !redirect) begin
            tag_pc[tag_wr] <= fetch_pc;
        end
        if (push) begin
            fifo_instr[wr_ptr[PTR_W-1:0]] <= bus.imem_resp_data;
            fifo_pc[wr_ptr[PTR_W-1:0]]    <= tag_pc[tag_rd];
        end
    end

    resp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_resp_valid && (in_flight == '0)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a latency-configurable memory model, an
// expected-PC scoreboard filled by the stimulus and drained by a delivery monitor.
module tb_instruction_fetch;
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic rst_n;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC       (32'h0000_0100),
        .FIFO_DEPTH     (2),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          grant    = 0;
    int          issued   = 0;
    int          mem_lat  = 1;
    int          cyc      = 0;
    int          rd_idx   = 0;
    logic [31:0] exp_q[$];
    pend_t       pend_q[$];

    assign bus.imem_req_ready = (issued < grant);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit && rd_idx != exp_q.size(); i++) @(negedge clk);
        check(name, 32'(exp_q.size() - rd_idx), 32'd0);
    endtask

    // Memory: accepts while granted, answers in order after mem_lat cycles, data = ~addr.
    always begin
        logic        hs;
        logic [31:0] hs_addr;
        logic        in_rst;
        @(negedge clk);
        hs      = bus.imem_req_valid && bus.imem_req_ready;
        hs_addr = bus.imem_req_addr;
        in_rst  = !rst_n;
        @(posedge clk);
        #1;
        if (in_rst) begin
            pend_q.delete();
        end else if (hs) begin
            pend_q.push_back('{addr: hs_addr, due: cyc + mem_lat});
            issued++;
        end
        cyc++;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = ~pend_q[0].addr;
            void'(pend_q.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            check("sb_has_entry", 32'(rd_idx < exp_q.size()), 32'd1);
            if (rd_idx < exp_q.size()) begin
                check("deliver_pc", bus.instruction_pc, exp_q[rd_idx]);
                check("deliver_instr", bus.instruction, ~exp_q[rd_idx]);
                rd_idx++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst_n              = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instruction", bus.instruction, 32'd0);
        check("rst_instruction_pc", bus.instruction_pc, 32'd0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_req_addr", bus.imem_req_addr, 32'h0000_0100);

        // Streaming from RESET_PC with 1-cycle memory and ready decode.
        tick();
        rst_n = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        grant += 3;
        @(negedge clk);
        check("t1_c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t1_c0_req_addr", bus.imem_req_addr, 32'h100);
        tick();
        @(negedge clk);
        check("t1_c1_req_addr", bus.imem_req_addr, 32'h104);
        check("t1_c1_instr_valid", 32'(bus.instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t1_c2_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("t1_c2_instruction_pc", bus.instruction_pc, 32'h100);
        drain("t1_drain", 40);

        // Decode backpressure fills the FIFO and throttles requests.
        tick();
        bus.instr_ready = 1'b0;
        base = issued;
        exp_q.push_back(32'h10C);
        exp_q.push_back(32'h110);
        exp_q.push_back(32'h114);
        grant += 3;
        repeat (10) tick();
        @(negedge clk);
        check("t2_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("t2_head_pc", bus.instruction_pc, 32'h10C);
        check("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("t2_req_addr", bus.imem_req_addr, 32'h114);
        check("t2_requests", 32'(issued - base), 32'd2);
        tick();
        bus.instr_ready = 1'b1;
        drain("t2_drain", 40);

        // Redirect with two requests in flight (0x118, 0x11C) on a 3-cycle memory.
        tick();
        mem_lat = 3;
        grant += 2;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h403;
        exp_q.push_back(32'h400);
        grant += 1;
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_req_addr", bus.imem_req_addr, 32'h400);
        check("t3_drop_cnt", 32'(dut.drop_cnt), 32'd2);
        drain("t3_drain", 40);

        // Redirect coinciding with a response and a request handshake.
        tick();
        mem_lat = 1;
        grant += 2;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h800;
        @(negedge clk);
        check("t4_in_flight_before", 32'(dut.in_flight), 32'd1);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_drop_cnt", 32'(dut.drop_cnt), 32'd1);
        check("t4_instr_valid_a", 32'(bus.instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t4_instr_valid_b", 32'(bus.instr_valid), 32'd0);
        check("t4_in_flight_after", 32'(dut.in_flight), 32'd0);
        check("t4_req_addr", bus.imem_req_addr, 32'h800);
        tick();
        exp_q.push_back(32'h800);
        grant += 1;
        drain("t4_drain", 40);

        // PC wrap from the top of the address space; low target bits ignored.
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        tick();
        bus.redirect_valid = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        grant += 2;
        @(negedge clk);
        check("t5_req_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("t5_req_addr_wrap", bus.imem_req_addr, 32'h0000_0000);
        drain("t5_drain", 40);

        // Reset mid-stream with one entry buffered.
        tick();
        bus.instr_ready = 1'b0;
        grant += 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.instr_valid) break;
        end
        check("t6_buffered_valid", 32'(bus.instr_valid), 32'd1);
        check("t6_buffered_pc", bus.instruction_pc, 32'h4);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_instruction", bus.instruction, 32'd0);
        check("t6_instruction_pc", bus.instruction_pc, 32'd0);
        check("t6_in_flight", 32'(dut.in_flight), 32'd0);
        check("t6_req_addr", bus.imem_req_addr, 32'h100);

        // Fetch restarts cleanly from RESET_PC.
        tick();
        bus.instr_ready = 1'b1;
        exp_q.push_back(32'h100);
        grant += 1;
        drain("t7_drain", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
